// File: rtl/dataset_streamer_if.sv
// Stream bundle for dataset_streamer: load port, feature port and prediction
// strobe. The master side is the environment (loader + predictor), the slave
// side is the streamer itself.
interface dataset_streamer_if #(
    parameter int DATA_W = 64
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;

    logic              feat_valid;
    logic [DATA_W-1:0] feat_data;
    logic              feat_last;
    logic              feat_ready;

    logic              pred_valid;
    logic [DATA_W-1:0] pred_data;

    modport master (
        output load_valid, load_data, feat_ready, pred_valid, pred_data,
        input  load_ready, feat_valid, feat_data, feat_last
    );

    modport slave (
        input  load_valid, load_data, feat_ready, pred_valid, pred_data,
        output load_ready, feat_valid, feat_data, feat_last
    );
endinterface

// File: rtl/dataset_streamer.sv
// dataset_streamer: holds ROWS samples of COLS features plus a label, streams
// the features of each row to a predictor, scores each returned prediction
// against the stored label and reports correct/total counts when done.
module dataset_streamer #(
    parameter int ROWS   = 100,
    parameter int COLS   = 15,
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(ROWS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    dataset_streamer_if.slave  bus,
    input  logic               start,
    input  logic               reload,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   correct_cnt,
    output logic [CNT_W-1:0]   total_cnt
);
    localparam int DEPTH  = ROWS * (COLS + 1);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int COL_W  = $clog2(COLS + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_STREAM,
        S_WAIT_PRED,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wp;
    logic [ADDR_W-1:0]   r_base;     // row * (COLS+1), kept incrementally
    logic [COL_W-1:0]    r_col;
    logic [CNT_W-1:0]    r_row;
    logic [CNT_W-1:0]    r_correct;
    logic [CNT_W-1:0]    r_total;
    logic                r_err;

    logic                w_load_fire;
    logic                w_load_last;
    logic                w_cmd_state;
    logic                w_reload;
    logic                w_start;
    logic                w_feat_fire;
    logic                w_last_col;
    logic                w_pred_fire;
    logic                w_last_row;
    logic                w_label_hit;
    logic [ADDR_W-1:0]   w_feat_addr;
    logic [ADDR_W-1:0]   w_label_addr;

    assign w_load_fire  = (r_state == S_LOAD) && bus.load_valid;
    assign w_load_last  = (r_wp == ADDR_W'(DEPTH - 1));
    assign w_cmd_state  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_reload     = w_cmd_state && reload;
    assign w_start      = w_cmd_state && start && !reload;   // reload wins
    assign w_feat_fire  = (r_state == S_STREAM) && bus.feat_ready;
    assign w_last_col   = (r_col == COL_W'(COLS - 1));
    assign w_pred_fire  = (r_state == S_WAIT_PRED) && bus.pred_valid;
    assign w_last_row   = (r_row == CNT_W'(ROWS - 1));
    assign w_feat_addr  = r_base + ADDR_W'(r_col);
    assign w_label_addr = r_base + ADDR_W'(COLS);
    assign w_label_hit  = (bus.pred_data == r_mem[w_label_addr]);

    assign err          = r_err;
    assign correct_cnt  = r_correct;
    assign total_cnt    = r_total;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_next         = r_state;
        bus.load_ready = 1'b0;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.feat_last  = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                bus.load_ready = 1'b1;
                if (w_load_fire && w_load_last) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (w_reload)     w_next = S_LOAD;
                else if (w_start) w_next = S_STREAM;
            end
            S_STREAM: begin
                busy           = 1'b1;
                bus.feat_valid = 1'b1;
                bus.feat_data  = r_mem[w_feat_addr];
                bus.feat_last  = w_last_col;
                if (w_feat_fire && w_last_col) w_next = S_WAIT_PRED;
            end
            S_WAIT_PRED: begin
                busy = 1'b1;
                if (w_pred_fire) w_next = w_last_row ? S_DONE : S_STREAM;
            end
            S_DONE: begin
                done = 1'b1;
                if (w_reload)     w_next = S_LOAD;
                else if (w_start) w_next = S_STREAM;
            end
            default: w_next = S_LOAD;
        endcase
    end

    // Sample storage, written only while loading.
    // NOTE: the array has no reset; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (w_load_fire) r_mem[r_wp] <= bus.load_data;
    end

    // Load pointer: wraps to 0 after the final word and on reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_wp <= '0;
        else if (w_load_fire) r_wp <= w_load_last ? '0 : r_wp + ADDR_W'(1);
        else if (w_reload)    r_wp <= '0;
    end

    // Row/column cursor for the feature stream and label lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_base <= '0;
        end else if (w_start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_base <= '0;
        end else if (w_feat_fire && !w_last_col) begin
            r_col  <= r_col + COL_W'(1);
        end else if (w_pred_fire && !w_last_row) begin
            r_row  <= r_row + CNT_W'(1);
            r_col  <= '0;
            r_base <= r_base + ADDR_W'(COLS + 1);
        end
    end

    // Score counters: cleared by an accepted start, bumped per prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_correct <= '0;
            r_total   <= '0;
        end else if (w_start) begin
            r_correct <= '0;
            r_total   <= '0;
        end else if (w_pred_fire) begin
            r_total <= r_total + CNT_W'(1);
            if (w_label_hit) r_correct <= r_correct + CNT_W'(1);
        end
    end

    // Sticky protocol error: a stray prediction outside WAIT_PRED sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_err <= 1'b0;
        else if (bus.pred_valid && r_state != S_WAIT_PRED)   r_err <= 1'b1;
        else if (w_start)                                    r_err <= 1'b0;
    end
endmodule
